seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 18 +
 rtl/seg_dwell_timer.sv | 45 ++++
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
//   state_e    : slot FSM states (ST_BLANK anti-ghost gap, ST_DRIVE lit phase)
//   SEG_BLANK  : active-low "all segments off" pattern
//   calc_dwell : cycles per digit slot from clock period (ns) and refresh rate (Hz)
package seg_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic int calc_dwell(input int clk_per, input int refr_rate);
    return 1_000_000_000 / (clk_per * refr_rate);
  endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Digit-slot timer. Counts 0..DWELL-1 per slot.
//   clk_i, reset_i : clock, synchronous active-high reset
//   blank_done_o   : current cycle is the last blank cycle of the slot
//   slot_done_o    : current cycle is the last cycle of the slot
//   slot_start_o   : the next cycle is cycle 0 of a slot
module seg_dwell_timer
  import seg_scan_pkg::*;
#(
  parameter int DWELL        = 40,
  parameter int BLANK_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic blank_done_o,
  output logic slot_done_o,
  output logic slot_start_o
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  if (DWELL <= BLANK_CYCLES || BLANK_CYCLES < 1) begin : g_bad_timing
    $error("seg_dwell_timer: need DWELL > BLANK_CYCLES >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  // Set by reset: the first active edge starts slot 0 from count 0 instead
  // of advancing, so the cycle right after reset is the first blank cycle.
  logic          restart_q;

  assign blank_done_o = !restart_q && (cnt_q == CW'(BLANK_CYCLES - 1));
  assign slot_done_o  = !restart_q && (cnt_q == CW'(DWELL - 1));
  assign slot_start_o = restart_q || slot_done_o;
  assign cnt_d        = slot_start_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      restart_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      restart_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display scanner with PWM brightness and
// frame-synchronous double-buffered digit data.
//   clk_i, reset_i  : clock, synchronous active-high reset
//   digit_data_i    : per-digit active-low cathode patterns (bit 7 = DP)
//   digit_en_i      : per-digit enable, sampled live
//   brightness_i    : PWM level, 15 = full on, sampled live
//   update_i        : one-cycle request to load digit_data_i
//   update_ack_o    : pulses when loaded data becomes visible (frame start)
//   anode_o         : active-low digit select, at most one bit low
//   cathode_o       : active-low segment drive
//   frame_start_o   : pulses in the first blank cycle of digit 0
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_SEGMENTS = 8,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_SEGMENTS-1:0][7:0] digit_data_i,
  input  logic [NUM_SEGMENTS-1:0]     digit_en_i,
  input  logic [3:0]                  brightness_i,
  input  logic                        update_i,
  output logic                        update_ack_o,
  output logic [NUM_SEGMENTS-1:0]     anode_o,
  output logic [7:0]                  cathode_o,
  output logic                        frame_start_o
);

  localparam int DWELL = calc_dwell(CLK_PER, REFR_RATE);
  localparam int IW    = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

  if (DWELL <= BLANK_CYCLES) begin : g_bad_dwell
    $error("seg_scan_ctrl: DWELL must exceed BLANK_CYCLES");
  end

  logic blank_done, slot_done, slot_start;

  seg_dwell_timer #(
    .DWELL       (DWELL),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done),
    .slot_start_o(slot_start)
  );

  state_e                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [3:0]                     pwm_q, pwm_d;
  logic                           pend_q, pend_d;
  logic [NUM_SEGMENTS-1:0][7:0]   stg_q, stg_d, shd_q, shd_d;
  logic [NUM_SEGMENTS-1:0]        anode_d;
  logic [7:0]                     cathode_d;
  logic                           frame_d, ack_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pwm_d     = '0;
    pend_d    = pend_q;
    stg_d     = stg_q;
    shd_d     = shd_q;
    ack_d     = 1'b0;
    anode_d   = '1;
    cathode_d = SEG_BLANK;

    case (state_q)
      ST_BLANK: if (blank_done) state_d = ST_DRIVE;
      ST_DRIVE: begin
        pwm_d = pwm_q + 4'd1;
        if (slot_done) begin
          state_d = ST_BLANK;
          idx_d   = (idx_q == IW'(NUM_SEGMENTS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Outputs are registered from next-state values so they line up with
    // the state they describe rather than lagging it by a cycle.
    frame_d = slot_start && (idx_d == '0);

    if (update_i) begin
      stg_d  = digit_data_i;
      pend_d = 1'b1;
    end
    // An update landing on the frame edge bypasses staging latency; either
    // way only one ack is produced per frame.
    if (frame_d && (update_i || pend_q)) begin
      shd_d  = update_i ? digit_data_i : stg_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end

    if (state_d == ST_DRIVE && digit_en_i[idx_d] && pwm_d <= brightness_i) begin
      anode_d[idx_d] = 1'b0;
      cathode_d      = shd_d[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_BLANK;
      idx_q         <= '0;
      pwm_q         <= '0;
      pend_q        <= 1'b0;
      stg_q         <= {NUM_SEGMENTS{SEG_BLANK}};
      shd_q         <= {NUM_SEGMENTS{SEG_BLANK}};
      anode_o       <= '1;
      cathode_o     <= SEG_BLANK;
      frame_start_o <= 1'b0;
      update_ack_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      pend_q        <= pend_d;
      stg_q         <= stg_d;
      shd_q         <= shd_d;
      anode_o       <= anode_d;
      cathode_o     <= cathode_d;
      frame_start_o <= frame_d;
      update_ack_o  <= ack_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 40-cycle slots (4 blank +
// 36 drive), 160-cycle frames. ph is the cycle position within the frame.
module tb_seg_scan_ctrl;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0][7:0] data = '1;
  logic [N-1:0]      en = '1;
  logic [3:0]        br = 4'd15;
  logic              upd = 1'b0;
  logic              update_ack, frame_start;
  logic [N-1:0]      anode;
  logic [7:0]        cathode;

  int                nchk = 0, nerr = 0;
  int                ph = 0;
  logic [N-1:0][7:0] exp_shd = '1;
  logic [N-1:0]      e_an;
  logic [7:0]        e_ca;
  logic              e_fs;

  localparam logic [N-1:0][7:0] PAT_A  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
  localparam logic [N-1:0][7:0] PAT_D1 = {8'h14, 8'h13, 8'h12, 8'h11};
  localparam logic [N-1:0][7:0] PAT_D2 = {8'h2A, 8'h2B, 8'h2C, 8'h2D};
  localparam logic [N-1:0][7:0] PAT_E  = {8'h99, 8'hB0, 8'hA4, 8'hF9};

  seg_scan_ctrl #(
    .NUM_SEGMENTS(N), .CLK_PER(10), .REFR_RATE(2_500_000), .BLANK_CYCLES(4)
  ) dut (
    .clk_i(clk), .reset_i(reset), .digit_data_i(data), .digit_en_i(en),
    .brightness_i(br), .update_i(upd), .update_ack_o(update_ack),
    .anode_o(anode), .cathode_o(cathode), .frame_start_o(frame_start)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 160;
  endtask

  // Expected outputs at frame position ph: slot = ph/40, blank for the first
  // 4 cycles of a slot, then pwm runs 0..15,0..15,0..3 over the 36 drive cycles.
  function automatic void calc_exp();
    int s, q;
    s = ph / 40;
    q = ph % 40;
    e_an = '1;
    e_ca = 8'hFF;
    e_fs = (ph == 0);
    if (q >= 4 && en[s] && ((q - 4) % 16) <= int'(br)) begin
      e_an[s] = 1'b0;
      e_ca    = exp_shd[s];
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    upd   = 1'b0;
    repeat (3) step();
    nchk++; if (anode !== 4'hF) begin nerr++; $display("FAIL reset_anode got %b exp 1111", anode); end
    nchk++; if (cathode !== 8'hFF) begin nerr++; $display("FAIL reset_cathode got %h exp ff", cathode); end
    nchk++; if (frame_start !== 1'b0) begin nerr++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
    nchk++; if (update_ack !== 1'b0) begin nerr++; $display("FAIL reset_update_ack got %b exp 0", update_ack); end
  endtask

  // Full-brightness scan: frame 0 shows reset data, update mid-frame, frame 1 shows PAT_A.
  task automatic test_scan();
    int lows [N];
    logic e_ack;
    foreach (lows[k]) lows[k] = 0;
    data = PAT_A; en = '1; br = 4'd15;
    reset = 1'b0;
    ph = 159;
    for (int i = 0; i < 320; i++) begin
      step();
      if (i == 160) exp_shd = PAT_A;
      calc_exp();
      e_ack = (i == 160);
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, e_ack}) begin
        nerr++;
        $display("FAIL scan i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=%b",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs, e_ack);
      end
      if (i >= 160) for (int j = 0; j < N; j++) if (anode[j] == 1'b0) lows[j]++;
      upd = (i == 80);
    end
    for (int j = 0; j < N; j++) begin
      nchk++; if (lows[j] != 36) begin nerr++; $display("FAIL scan_lit_cycles digit %0d got %0d exp 36", j, lows[j]); end
    end
  endtask

  task automatic test_pwm();
    int lows [N];
    foreach (lows[k]) lows[k] = 0;
    br = 4'd3;
    for (int i = 0; i < 160; i++) begin
      step();
      calc_exp();
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, 1'b0}) begin
        nerr++;
        $display("FAIL pwm i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=0",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs);
      end
      for (int j = 0; j < N; j++) if (anode[j] == 1'b0) lows[j]++;
    end
    // pwm 0..3 lit in each of three pwm runs within 36 drive cycles: 4+4+4
    for (int j = 0; j < N; j++) begin
      nchk++; if (lows[j] != 12) begin nerr++; $display("FAIL pwm_lit_cycles digit %0d got %0d exp 12", j, lows[j]); end
    end
    br = 4'd15;
  endtask

  task automatic test_digit_en();
    int lows2 = 0, lows0 = 0, bad_an = 0;
    en = 4'b1011;
    for (int i = 0; i < 160; i++) begin
      step();
      calc_exp();
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, 1'b0}) begin
        nerr++;
        $display("FAIL digit_en i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=0",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs);
      end
      if (anode == 4'b1011) bad_an++;
      if (anode[2] == 1'b0) lows2++;
      if (anode[0] == 1'b0) lows0++;
    end
    nchk++; if (bad_an != 0) begin nerr++; $display("FAIL digit_en_anode1011 got %0d exp 0", bad_an); end
    nchk++; if (lows2 != 0) begin nerr++; $display("FAIL digit_en_dark got %0d exp 0", lows2); end
    nchk++; if (lows0 != 36) begin nerr++; $display("FAIL digit_en_other got %0d exp 36", lows0); end
    en = '1;
  endtask

  task automatic test_double_update();
    int acks = 0;
    logic e_ack;
    for (int i = 0; i < 320; i++) begin
      step();
      if (i == 160) exp_shd = PAT_D2;
      calc_exp();
      e_ack = (i == 160);
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, e_ack}) begin
        nerr++;
        $display("FAIL double_update i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=%b",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs, e_ack);
      end
      if (update_ack) acks++;
      upd = (i == 20) || (i == 60);
      if (i == 20) data = PAT_D1;
      if (i == 60) data = PAT_D2;
    end
    nchk++; if (acks != 1) begin nerr++; $display("FAIL double_update_ack_count got %0d exp 1", acks); end
  endtask

  task automatic test_boundary_update();
    logic e_ack;
    for (int i = 0; i < 320; i++) begin
      step();
      if (i == 160) exp_shd = PAT_E;
      calc_exp();
      e_ack = (i == 160);
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, e_ack}) begin
        nerr++;
        $display("FAIL boundary_update i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=%b",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs, e_ack);
      end
      if (i == 164) begin
        nchk++;
        if ({anode, cathode} !== {4'b1110, 8'hF9}) begin
          nerr++;
          $display("FAIL boundary_digit0 got an=%b ca=%h exp an=1110 ca=f9", anode, cathode);
        end
      end
      upd = (i == 159);
      if (i == 159) data = PAT_E;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 96; i++) begin
      step();
      calc_exp();
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, 1'b0}) begin
        nerr++;
        $display("FAIL reset_mid_pre i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=0",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs);
      end
      upd = (i == 50);
      if (i == 50) data = PAT_A;
    end
    reset = 1'b1;
    step();
    nchk++;
    if ({anode, cathode, frame_start, update_ack} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_mid_abort got an=%b ca=%h fs=%b ack=%b exp an=1111 ca=ff fs=0 ack=0",
               anode, cathode, frame_start, update_ack);
    end
    step();
    reset = 1'b0;
    exp_shd = '1;
    ph = 159;
    for (int i = 0; i < 160; i++) begin
      step();
      calc_exp();
      nchk++;
      if ({anode, cathode, frame_start, update_ack} !== {e_an, e_ca, e_fs, 1'b0}) begin
        nerr++;
        $display("FAIL reset_mid_post i=%0d got an=%b ca=%h fs=%b ack=%b exp an=%b ca=%h fs=%b ack=0",
                 i, anode, cathode, frame_start, update_ack, e_an, e_ca, e_fs);
      end
      if (i == 4) begin
        nchk++;
        if ({anode, cathode} !== {4'b1110, 8'hFF}) begin
          nerr++;
          $display("FAIL reset_mid_digit0 got an=%b ca=%h exp an=1110 ca=ff", anode, cathode);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_digit_en();
    test_double_update();
    test_boundary_update();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
